// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic-array input side:
//   - feeder_state_t : state encoding of the skew feeder FSM
//   - skew_depth()   : delay-line depth for a given edge lane index
// -----------------------------------------------------------------------------
package systolic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } feeder_state_t;

    // Row/column i of the array must see its operand i cycles after lane 0.
    function automatic int skew_depth(input int lane);
        return lane;
    endfunction

endpackage

// File: rtl/cmn_EnResetReg.sv
// -----------------------------------------------------------------------------
// cmn_EnResetReg
// Enabled register with synchronous active-high reset (reset wins over enable).
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset to p_reset_value
//   i_en  : load enable
//   i_d   : next value
//   o_q   : registered value
// -----------------------------------------------------------------------------
module cmn_EnResetReg #(
    parameter int                 p_nbits       = 1,
    parameter logic [p_nbits-1:0] p_reset_value = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic [p_nbits-1:0] i_d,
    output logic [p_nbits-1:0] o_q
);

    logic [p_nbits-1:0] r_q;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of its neighbours; blocking = here would race.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= p_reset_value;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/systolic_skew_lane.sv
// -----------------------------------------------------------------------------
// systolic_skew_lane
// Enabled, clearable delay line of DEPTH stages. DEPTH=0 is a plain wire.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset
//   i_clr : synchronous clear of every stage (same effect as rst)
//   i_en  : advance the line by one stage
//   i_d   : lane input
//   o_q   : lane output, i_d delayed by DEPTH enabled cycles
// -----------------------------------------------------------------------------
module systolic_skew_lane #(
    parameter int NBITS = 16,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [NBITS-1:0] i_d,
    output logic [NBITS-1:0] o_q
);

    if (DEPTH == 0) begin : g_wire
        // Control inputs are intentionally unused on a zero-depth lane.
        logic w_unused;
        assign w_unused = &{1'b0, clk, rst, i_clr, i_en};
        assign o_q      = i_d;
    end else begin : g_regs
        logic             w_rst;
        logic [NBITS-1:0] w_tap [DEPTH+1];

        assign w_rst    = rst | i_clr;
        assign w_tap[0] = i_d;

        for (genvar s = 0; s < DEPTH; s++) begin : g_stage
            cmn_EnResetReg #(.p_nbits(NBITS)) u_reg (
                .clk  (clk),
                .rst  (w_rst),
                .i_en (i_en),
                .i_d  (w_tap[s]),
                .o_q  (w_tap[s+1])
            );
        end

        assign o_q = w_tap[DEPTH];
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder
// Input-side driver for a SIZE x SIZE systolic matrix-multiply array. Accepts
// one k-step (x column + w row) per recv handshake, skews lane i by i enabled
// cycles, drives the array enable / accumulator clear, flushes zeros after the
// last beat and then raises done.
//
// Optional feature: define SYSTOLIC_FEEDER_STALL_CNT_EN to add output
// stall_cnt (32-bit saturating count of FEED cycles with recv_val=0).
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start, cfg_len        : job start (IDLE/DONE only) and beat count
//   recv_msg_x/w, recv_val, recv_rdy : beat handshake, lane i = [i*NBITS +: NBITS]
//   x_edge, w_edge        : skewed operands into the array's left/top edges
//   array_en, array_clr   : global PE enable, one-cycle accumulator clear
//   done                  : every PE sum is final
//   stall_cnt             : (optional) FEED cycles without a valid beat
// -----------------------------------------------------------------------------
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int NBITS = 16,
    parameter int SIZE  = 4,
    parameter int LBITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LBITS-1:0]      cfg_len,
    input  logic [SIZE*NBITS-1:0] recv_msg_x,
    input  logic [SIZE*NBITS-1:0] recv_msg_w,
    input  logic                  recv_val,
    output logic                  recv_rdy,
    output logic [SIZE*NBITS-1:0] x_edge,
    output logic [SIZE*NBITS-1:0] w_edge,
    output logic                  array_en,
    output logic                  array_clr,
    output logic                  done
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    // Zeros must ripple through the deepest x and w skews before PE(SIZE-1,SIZE-1) is final.
    localparam int             DRAIN_LEN  = 2 * (SIZE - 1);
    localparam int             DBW        = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;
    localparam logic [DBW-1:0] DRAIN_LAST = DBW'(DRAIN_LEN - 1);

    feeder_state_t         r_state;
    logic [LBITS-1:0]      r_len;
    logic [LBITS-1:0]      r_count;
    logic [DBW-1:0]        r_drain;
    logic                  r_recv_rdy;
    logic                  r_array_clr;
    logic                  r_done;

    logic                  w_fire;
    logic                  w_array_en;
    logic [SIZE*NBITS-1:0] w_push_x;
    logic [SIZE*NBITS-1:0] w_push_w;

    assign w_fire     = recv_val & r_recv_rdy;
    assign w_array_en = w_fire | (r_state == ST_DRAIN);
    // Anything other than a real beat pushes zeros (drain, stalls, idle).
    assign w_push_x   = w_fire ? recv_msg_x : '0;
    assign w_push_w   = w_fire ? recv_msg_w : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_count     <= '0;
            r_drain     <= '0;
            r_recv_rdy  <= 1'b0;
            r_array_clr <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_array_clr <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state     <= ST_CLEAR;
                        r_len       <= cfg_len;
                        r_count     <= '0;
                        r_array_clr <= 1'b1;
                        r_done      <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (r_len == '0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state    <= ST_FEED;
                        r_recv_rdy <= 1'b1;
                    end
                end
                ST_FEED: begin
                    if (w_fire) begin
                        if (r_count == r_len - LBITS'(1)) begin
                            r_recv_rdy <= 1'b0;
                            if (DRAIN_LEN == 0) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_DRAIN;
                                r_drain <= '0;
                            end
                        end else begin
                            r_count <= r_count + LBITS'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == DRAIN_LAST) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain + DBW'(1);
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_recv_rdy <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        systolic_skew_lane #(.NBITS(NBITS), .DEPTH(skew_depth(i))) u_x (
            .clk   (clk),
            .rst   (rst),
            .i_clr (r_array_clr),
            .i_en  (w_array_en),
            .i_d   (w_push_x[i*NBITS +: NBITS]),
            .o_q   (x_edge[i*NBITS +: NBITS])
        );
        systolic_skew_lane #(.NBITS(NBITS), .DEPTH(skew_depth(i))) u_w (
            .clk   (clk),
            .rst   (rst),
            .i_clr (r_array_clr),
            .i_en  (w_array_en),
            .i_d   (w_push_w[i*NBITS +: NBITS]),
            .o_q   (w_edge[i*NBITS +: NBITS])
        );
    end

`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || r_state == ST_CLEAR) begin
            r_stall_cnt <= '0;
        end else if (r_state == ST_FEED && !recv_val && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign recv_rdy  = r_recv_rdy;
    assign array_en  = w_array_en;
    assign array_clr = r_array_clr;
    assign done      = r_done;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_skew_feeder
// Directed bench for systolic_skew_feeder (NBITS=16, SIZE=4, LBITS=8).
// Inputs change 1 time unit after posedge; outputs are sampled 2 units after.
// -----------------------------------------------------------------------------
module tb_systolic_skew_feeder;

    localparam int NBITS = 16;
    localparam int SIZE  = 4;
    localparam int LBITS = 8;
    localparam int VW    = SIZE * NBITS;
    localparam int DRAIN = 2 * (SIZE - 1);
    localparam logic [VW-1:0] JUNK = {SIZE{16'hA5A5}};

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LBITS-1:0] cfg_len;
    logic [VW-1:0]    recv_msg_x;
    logic [VW-1:0]    recv_msg_w;
    logic             recv_val;
    logic             recv_rdy;
    logic [VW-1:0]    x_edge;
    logic [VW-1:0]    w_edge;
    logic             array_en;
    logic             array_clr;
    logic             done;
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    logic [31:0]      stall_cnt;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [NBITS-1:0] x_tbl [4][SIZE];
    logic [NBITS-1:0] w_tbl [4][SIZE];

    always #5 clk = ~clk;

    systolic_skew_feeder #(.NBITS(NBITS), .SIZE(SIZE), .LBITS(LBITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_len    (cfg_len),
        .recv_msg_x (recv_msg_x),
        .recv_msg_w (recv_msg_w),
        .recv_val   (recv_val),
        .recv_rdy   (recv_rdy),
        .x_edge     (x_edge),
        .w_edge     (w_edge),
        .array_en   (array_en),
        .array_clr  (array_clr),
        .done       (done)
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Beat k: x lane i = base + k*SIZE + i + 1, w lane i = 0x100*(k+1) + base + i.
    task automatic load_tbl(input int base);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < SIZE; i++) begin
                x_tbl[k][i] = 16'(base + k * SIZE + i + 1);
                w_tbl[k][i] = 16'(256 * (k + 1) + base + i);
            end
        end
    endtask

    task automatic set_beat(input int k);
        for (int i = 0; i < SIZE; i++) begin
            recv_msg_x[i*NBITS +: NBITS] = x_tbl[k][i];
            recv_msg_w[i*NBITS +: NBITS] = w_tbl[k][i];
        end
    endtask

    // Edge contents during the m-th enabled cycle after the first fire:
    // lane i carries beat m-i. zero0 forces lane 0 (passthrough) to 0.
    function automatic logic [VW-1:0] exp_edge(input bit is_w, input int m,
                                               input int len, input bit zero0);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (!(zero0 && i == 0) && (m - i) >= 0 && (m - i) < len) begin
                v[i*NBITS +: NBITS] = is_w ? w_tbl[m-i][i] : x_tbl[m-i][i];
            end
        end
        return v;
    endfunction

    // Drives start in the current cycle, checks the CLEAR cycle, and returns
    // positioned in the cycle after CLEAR.
    task automatic do_start(input int len, input logic exp_done_now);
        start      = 1'b1;
        cfg_len    = LBITS'(len);
        recv_val   = 1'b1;
        recv_msg_x = JUNK;
        recv_msg_w = JUNK;
        #1;
        check_bit("start:done", done, exp_done_now);
        check_bit("start:clr", array_clr, 1'b0);
        tick();
        start   = 1'b0;
        cfg_len = 8'hFF;
        #1;
        check_bit("clear:clr", array_clr, 1'b1);
        check_bit("clear:rdy", recv_rdy, 1'b0);
        check_bit("clear:en", array_en, 1'b0);
        check_bit("clear:done", done, 1'b0);
        check_vec("clear:x_edge", x_edge, '0);
        tick();
    endtask

    // Runs a job from its first FEED cycle to one cycle after done rises.
    // stall_len idle cycles are inserted just before beat stall_at.
    task automatic run_feed(input int len, input int stall_at, input int stall_len);
        int  k          = 0;
        int  m          = 0;
        int  drain      = 0;
        int  stall_left = stall_len;
        bit  fire;
        bit  in_feed;
        bit  exp_en;
        bit  exp_done;
        for (int cyc = 0; cyc < len + stall_len + DRAIN + 1; cyc++) begin
            in_feed = (k < len);
            fire    = 1'b0;
            if (in_feed && k == stall_at && stall_left > 0) begin
                recv_val   = 1'b0;
                recv_msg_x = JUNK;
                recv_msg_w = JUNK;
                stall_left--;
            end else if (in_feed) begin
                set_beat(k);
                recv_val = 1'b1;
                fire     = 1'b1;
            end else begin
                recv_val   = 1'b1;
                recv_msg_x = JUNK;
                recv_msg_w = JUNK;
            end
            exp_en   = fire || (!in_feed && drain < DRAIN);
            exp_done = !in_feed && drain >= DRAIN;
            #1;
            check_bit($sformatf("rdy c%0d", cyc), recv_rdy, in_feed);
            check_bit($sformatf("en c%0d", cyc), array_en, exp_en);
            check_bit($sformatf("done c%0d", cyc), done, exp_done);
            check_bit($sformatf("clr c%0d", cyc), array_clr, 1'b0);
            check_vec($sformatf("x_edge c%0d", cyc), x_edge, exp_edge(1'b0, m, len, !exp_en));
            check_vec($sformatf("w_edge c%0d", cyc), w_edge, exp_edge(1'b1, m, len, !exp_en));
            if (fire)     k++;
            if (exp_en)   m++;
            if (!in_feed) drain++;
            tick();
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        cfg_len    = '0;
        recv_val   = 1'b0;
        recv_msg_x = '0;
        recv_msg_w = '0;
        tick();
        tick();
        #1;
        check_bit("reset:rdy", recv_rdy, 1'b0);
        check_bit("reset:en", array_en, 1'b0);
        check_bit("reset:clr", array_clr, 1'b0);
        check_bit("reset:done", done, 1'b0);
        check_vec("reset:x_edge", x_edge, '0);
        check_vec("reset:w_edge", w_edge, '0);
        rst = 1'b0;
        tick();

        // Basic skew: len=3, x beats {1,2,3,4},{5,6,7,8},{9,10,11,12}.
        load_tbl(0);
        do_start(3, 1'b0);
        run_feed(3, -1, 0);

        // Restart from DONE with a new length and a 2-cycle stall before beat 1.
        load_tbl(16);
        do_start(4, 1'b1);
        run_feed(4, 1, 2);
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
        check_vec("stall_cnt after 2-gap", VW'(stall_cnt), VW'(2));
`endif

        // Zero length: CLEAR straight to DONE.
        do_start(0, 1'b1);
        recv_val = 1'b1;
        #1;
        check_bit("len0:done", done, 1'b1);
        check_bit("len0:rdy", recv_rdy, 1'b0);
        check_bit("len0:en", array_en, 1'b0);
        check_bit("len0:clr", array_clr, 1'b0);
        tick();
        #1;
        check_bit("len0:done hold", done, 1'b1);
        check_bit("len0:rdy hold", recv_rdy, 1'b0);

        // Mid-job reset; start during FEED is ignored.
        load_tbl(32);
        do_start(3, 1'b1);
        set_beat(0);
        recv_val = 1'b1;
        start    = 1'b1;
        cfg_len  = 8'd9;
        #1;
        check_bit("mid:en beat0", array_en, 1'b1);
        tick();
        start = 1'b0;
        set_beat(1);
        #1;
        check_bit("mid:start ignored clr", array_clr, 1'b0);
        check_bit("mid:start ignored rdy", recv_rdy, 1'b1);
        check_vec("mid:x_edge beat1", x_edge, exp_edge(1'b0, 1, 3, 1'b0));
        tick();
        rst = 1'b1;
        set_beat(2);
        tick();
        rst      = 1'b0;
        recv_val = 1'b0;
        #1;
        check_bit("post-rst:rdy", recv_rdy, 1'b0);
        check_bit("post-rst:en", array_en, 1'b0);
        check_bit("post-rst:clr", array_clr, 1'b0);
        check_bit("post-rst:done", done, 1'b0);
        check_vec("post-rst:x_edge", x_edge, '0);
        check_vec("post-rst:w_edge", w_edge, '0);
        load_tbl(48);
        do_start(1, 1'b0);
        run_feed(1, -1, 0);

`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
        // Five idle FEED cycles, then the count clears on the next CLEAR.
        do_start(1, 1'b1);
        run_feed(1, 0, 5);
        check_vec("stall_cnt 5", VW'(stall_cnt), VW'(5));
        do_start(2, 1'b1);
        #1;
        check_vec("stall_cnt cleared", VW'(stall_cnt), VW'(0));
        run_feed(2, -1, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
